// File: rtl/pingpong_pkg.sv
// Shared widths, bank-count type and occupancy constants for the ping-pong buffer.
package pingpong_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 3;

  typedef logic [1:0] count_t;

  localparam count_t CNT_EMPTY = 2'd0;
  localparam count_t CNT_FULL  = 2'd2;
endpackage

// File: rtl/pingpong_bank.sv
// One storage bank: a single write port and two registered read ports (read-first).
module pingpong_bank
  import pingpong_pkg::*;
#(
  parameter int DW    = DATA_WIDTH,
  parameter int AW    = ADDR_WIDTH,
  parameter int DEPTH = 2 ** AW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          ra_en_i,
  input  logic [AW-1:0] ra_addr_i,
  output logic [DW-1:0] ra_q_o,
  input  logic          rb_en_i,
  input  logic [AW-1:0] rb_addr_i,
  output logic [DW-1:0] rb_q_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] ra_q_q;
  logic [DW-1:0] rb_q_q;

  // Storage array: no reset so contents survive a reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read registers sample the pre-write word, giving read-first collisions.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ra_q_q <= {DW{1'b0}};
      rb_q_q <= {DW{1'b0}};
    end else begin
      if (ra_en_i) begin
        ra_q_q <= mem_q[ra_addr_i];
      end
      if (rb_en_i) begin
        rb_q_q <= mem_q[rb_addr_i];
      end
    end
  end

  assign ra_q_o = ra_q_q;
  assign rb_q_o = rb_q_q;

endmodule

// File: rtl/pingpong_buf.sv
// Two-bank ping-pong channel memory with full/empty bank-ownership handshake.
module pingpong_buf #(
  parameter int DATA_WIDTH = pingpong_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = pingpong_pkg::ADDR_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic [ADDR_WIDTH-1:0] i_address0,
  input  logic                  i_ce0,
  input  logic                  i_we0,
  input  logic [DATA_WIDTH-1:0] i_d0,
  output logic [DATA_WIDTH-1:0] i_q0,
  input  logic                  i_write,
  output logic                  i_full_n,
  input  logic [ADDR_WIDTH-1:0] t_address0,
  input  logic                  t_ce0,
  output logic [DATA_WIDTH-1:0] t_q0,
  input  logic                  t_read,
  output logic                  t_empty_n
);
  import pingpong_pkg::*;

  logic   iptr_q, iptr_d;
  logic   tptr_q, tptr_d;
  count_t count_q, count_d;
  logic   full_n_q, full_n_d;
  logic   empty_n_q, empty_n_d;
  logic   i_sel_q, i_sel_d;
  logic   t_sel_q, t_sel_d;
  logic   commit_s, release_s;

  logic [1:0]            wr_en_s;
  logic [1:0]            ra_en_s;
  logic [1:0]            rb_en_s;
  logic [DATA_WIDTH-1:0] ra_q_s [2];
  logic [DATA_WIDTH-1:0] rb_q_s [2];

  // Steer each port to the bank it currently owns (pre-toggle pointer).
  always_comb begin
    wr_en_s          = 2'b00;
    ra_en_s          = 2'b00;
    rb_en_s          = 2'b00;
    wr_en_s[iptr_q]  = i_ce0 & i_we0 & full_n_q;
    ra_en_s[iptr_q]  = i_ce0 & ~i_we0;
    rb_en_s[tptr_q]  = t_ce0;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pingpong_bank #(
      .DW    (DATA_WIDTH),
      .AW    (ADDR_WIDTH),
      .DEPTH (DEPTH)
    ) u_bank (
      .clk_i     (ap_clk),
      .rst_i     (ap_rst),
      .we_i      (wr_en_s[b]),
      .waddr_i   (i_address0),
      .wdata_i   (i_d0),
      .ra_en_i   (ra_en_s[b]),
      .ra_addr_i (i_address0),
      .ra_q_o    (ra_q_s[b]),
      .rb_en_i   (rb_en_s[b]),
      .rb_addr_i (t_address0),
      .rb_q_o    (rb_q_s[b])
    );
  end

  // Commit/release bookkeeping and the registered flags derived from the next count.
  always_comb begin
    commit_s  = i_write & full_n_q;
    release_s = t_read & empty_n_q;
    iptr_d    = iptr_q;
    tptr_d    = tptr_q;
    count_d   = count_q;
    i_sel_d   = i_sel_q;
    t_sel_d   = t_sel_q;

    if (commit_s) begin
      iptr_d = ~iptr_q;
    end else begin
      iptr_d = iptr_q;
    end
    if (release_s) begin
      tptr_d = ~tptr_q;
    end else begin
      tptr_d = tptr_q;
    end

    case ({commit_s, release_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Remember which bank fed each read register so q holds while ce is low.
    if (i_ce0 && !i_we0) begin
      i_sel_d = iptr_q;
    end else begin
      i_sel_d = i_sel_q;
    end
    if (t_ce0) begin
      t_sel_d = tptr_q;
    end else begin
      t_sel_d = t_sel_q;
    end

    full_n_d  = (count_d != CNT_FULL);
    empty_n_d = (count_d != CNT_EMPTY);
  end

  // Control state register.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      iptr_q    <= 1'b0;
      tptr_q    <= 1'b0;
      count_q   <= CNT_EMPTY;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
      i_sel_q   <= 1'b0;
      t_sel_q   <= 1'b0;
    end else begin
      iptr_q    <= iptr_d;
      tptr_q    <= tptr_d;
      count_q   <= count_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
      i_sel_q   <= i_sel_d;
      t_sel_q   <= t_sel_d;
    end
  end

  assign i_q0      = ra_q_s[i_sel_q];
  assign t_q0      = rb_q_s[t_sel_q];
  assign i_full_n  = full_n_q;
  assign t_empty_n = empty_n_q;

endmodule

// File: tb/tb_pingpong_buf.sv
// Self-checking bench for pingpong_buf: directed vector table, reset/corner sequences, random vs. model.
module tb_pingpong_buf;

  logic        ap_clk;
  logic        ap_rst;
  logic [2:0]  i_address0;
  logic        i_ce0;
  logic        i_we0;
  logic [31:0] i_d0;
  logic [31:0] i_q0;
  logic        i_write;
  logic        i_full_n;
  logic [2:0]  t_address0;
  logic        t_ce0;
  logic [31:0] t_q0;
  logic        t_read;
  logic        t_empty_n;

  int checks;
  int errors;

  pingpong_buf dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .i_address0 (i_address0),
    .i_ce0      (i_ce0),
    .i_we0      (i_we0),
    .i_d0       (i_d0),
    .i_q0       (i_q0),
    .i_write    (i_write),
    .i_full_n   (i_full_n),
    .t_address0 (t_address0),
    .t_ce0      (t_ce0),
    .t_q0       (t_q0),
    .t_read     (t_read),
    .t_empty_n  (t_empty_n)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic        ice, iwe;
    logic [2:0]  ia;
    logic [31:0] id;
    logic        iw;
    logic        tce;
    logic [2:0]  ta;
    logic        tr;
    logic        full_n, empty_n;
    logic        chk_iq;
    logic [31:0] iq;
    logic        chk_tq;
    logic [31:0] tq;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input bit ice, input bit iwe, input int ia, input int id,
                              input bit iw, input bit tce, input int ta, input bit tr,
                              input bit fn, input bit en, input bit ciq, input int eiq,
                              input bit ctq, input int etq);
    vec_t v;
    v.ice = ice; v.iwe = iwe; v.ia = 3'(ia); v.id = 32'(id); v.iw = iw;
    v.tce = tce; v.ta = 3'(ta); v.tr = tr; v.full_n = fn; v.empty_n = en;
    v.chk_iq = ciq; v.iq = 32'(eiq); v.chk_tq = ctq; v.tq = 32'(etq);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit ice, input bit iwe, input logic [2:0] ia, input logic [31:0] id,
                       input bit iw, input bit tce, input logic [2:0] ta, input bit tr);
    i_ce0 = ice; i_we0 = iwe; i_address0 = ia; i_d0 = id; i_write = iw;
    t_ce0 = tce; t_address0 = ta; t_read = tr;
  endtask

  // reference model state
  logic [31:0] m_mem   [2][8];
  bit          m_known [2][8];
  int          m_iptr, m_tptr, m_count;
  logic [31:0] e_iq, e_tq;
  bit          e_iqk, e_tqk;

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    ap_rst = 1'b1;
    #2;
    chk("reset_full_n", {31'd0, i_full_n}, 32'd1);
    chk("reset_empty_n", {31'd0, t_empty_n}, 32'd0);
    chk("reset_iq", i_q0, 32'd0);
    chk("reset_tq", t_q0, 32'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;

    // single pass
    for (int k = 0; k < 5; k++) tbl.push_back(mk(1,1,k,k*k,0, 0,0,0, 1,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 0,0,0, 1,1, 0,0,0,0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0,0,0,0,0, 1,k,0, 1,1, 0,0,1,k*k));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0, 1,1, 0,0,1,16));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1, 1,0, 0,0,1,16));
    // full: two commits, then a dropped write and ignored commit
    tbl.push_back(mk(1,1,0,7,0, 0,0,0, 1,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 0,0,0, 1,1, 0,0,0,0));
    tbl.push_back(mk(1,1,0,8,0, 0,0,0, 1,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 0,0,0, 0,1, 0,0,0,0));
    tbl.push_back(mk(1,1,0,99,1, 0,0,0, 0,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0, 0,1, 0,0,1,7));
    tbl.push_back(mk(1,0,0,0,0, 0,0,0, 0,1, 1,7,0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1, 1,1, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0, 1,0,0, 1,1, 0,0,1,8));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1, 1,0, 0,0,0,0));
    // ping-pong overlap, then simultaneous commit+release at count=1
    for (int k = 0; k < 5; k++) tbl.push_back(mk(1,1,k,k+1,0, 0,0,0, 1,0, 0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1, 0,0,0, 1,1, 0,0,0,0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(1,1,k,10*(k+1),0, 1,k,0, 1,1, 0,0,1,k+1));
    tbl.push_back(mk(0,0,0,0,1, 0,0,1, 1,1, 0,0,0,0));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(0,0,0,0,0, 1,k,0, 1,1, 0,0,1,10*(k+1)));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1, 1,0, 0,0,0,0));
    // empty misuse and read-first collision
    tbl.push_back(mk(0,0,0,0,0, 0,0,1, 1,0, 0,0,0,0));
    tbl.push_back(mk(1,1,2,77,0, 1,2,0, 1,0, 0,0,1,3));
    tbl.push_back(mk(1,0,2,0,0, 1,2,0, 1,0, 1,77,1,77));

    for (int n = 0; n < tbl.size(); n++) begin
      @(negedge ap_clk);
      drive(tbl[n].ice, tbl[n].iwe, tbl[n].ia, tbl[n].id, tbl[n].iw, tbl[n].tce, tbl[n].ta, tbl[n].tr);
      @(posedge ap_clk);
      #1;
      chk($sformatf("vec%0d_full_n", n), {31'd0, i_full_n}, {31'd0, tbl[n].full_n});
      chk($sformatf("vec%0d_empty_n", n), {31'd0, t_empty_n}, {31'd0, tbl[n].empty_n});
      if (tbl[n].chk_iq) chk($sformatf("vec%0d_iq", n), i_q0, tbl[n].iq);
      if (tbl[n].chk_tq) chk($sformatf("vec%0d_tq", n), t_q0, tbl[n].tq);
    end

    // mid-cycle async reset while a bank is committed
    @(negedge ap_clk);
    drive(1'b1, 1'b1, 3'd1, 32'h55, 1'b1, 1'b0, 3'd0, 1'b0);
    @(negedge ap_clk);
    drive(1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("pre_rst_empty_n", {31'd0, t_empty_n}, 32'd1);
    #1 ap_rst = 1'b1;
    #1;
    chk("arst_full_n", {31'd0, i_full_n}, 32'd1);
    chk("arst_empty_n", {31'd0, t_empty_n}, 32'd0);
    chk("arst_iq", i_q0, 32'd0);
    chk("arst_tq", t_q0, 32'd0);
    @(negedge ap_clk);
    ap_rst = 1'b0;

    // random traffic against the behavioural model
    m_iptr = 0; m_tptr = 0; m_count = 0;
    e_iq = 32'd0; e_tq = 32'd0; e_iqk = 1'b1; e_tqk = 1'b1;
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 8; a++) begin
        m_known[b][a] = 1'b0;
        m_mem[b][a] = 32'd0;
      end

    for (int c = 0; c < 600; c++) begin
      bit r_ice, r_iwe, r_iw, r_tce, r_tr, acc_c, acc_r;
      logic [2:0] r_ia, r_ta;
      logic [31:0] r_id;
      @(negedge ap_clk);
      r_ice = ($urandom_range(0, 1) == 1);
      r_iwe = ($urandom_range(0, 2) != 0);
      r_ia  = 3'($urandom_range(0, 7));
      r_id  = $urandom;
      r_iw  = ($urandom_range(0, 3) == 0);
      r_tce = ($urandom_range(0, 1) == 1);
      r_ta  = 3'($urandom_range(0, 7));
      r_tr  = ($urandom_range(0, 4) == 0);
      drive(r_ice, r_iwe, r_ia, r_id, r_iw, r_tce, r_ta, r_tr);

      if (r_ice && !r_iwe) begin
        e_iq = m_mem[m_iptr][r_ia];
        e_iqk = m_known[m_iptr][r_ia];
      end
      if (r_tce) begin
        e_tq = m_mem[m_tptr][r_ta];
        e_tqk = m_known[m_tptr][r_ta];
      end
      if (r_ice && r_iwe && m_count < 2) begin
        m_mem[m_iptr][r_ia] = r_id;
        m_known[m_iptr][r_ia] = 1'b1;
      end
      acc_c = r_iw && (m_count < 2);
      acc_r = r_tr && (m_count > 0);
      if (acc_c) begin m_iptr = 1 - m_iptr; m_count = m_count + 1; end
      if (acc_r) begin m_tptr = 1 - m_tptr; m_count = m_count - 1; end

      @(posedge ap_clk);
      #1;
      chk($sformatf("rnd%0d_full_n", c), {31'd0, i_full_n}, (m_count != 2) ? 32'd1 : 32'd0);
      chk($sformatf("rnd%0d_empty_n", c), {31'd0, t_empty_n}, (m_count != 0) ? 32'd1 : 32'd0);
      if (e_iqk) chk($sformatf("rnd%0d_iq", c), i_q0, e_iq);
      if (e_tqk) chk($sformatf("rnd%0d_tq", c), t_q0, e_tq);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pingpong_buf.md
# pingpong_buf

Two-bank ping-pong channel memory that sits between a dataflow producer stage (memory-port writer, e.g. the squaring stage driving `E_address0/E_ce0/E_we0/E_d0`) and the next consumer stage (memory-port reader). It is the responder for both memory ports: it serves write and read requests with BRAM-style 1-cycle read latency. It also tracks bank ownership through a full/empty handshake, so the producer can fill one bank while the consumer drains the other.

## Interface
Parameters:
- `DATA_WIDTH`, 32: word width.
- `ADDR_WIDTH`, 3: address width per bank.
- `DEPTH`, 8: words per bank; must equal 2**ADDR_WIDTH.

Ports:
- `ap_clk`  in  1  single clock, all logic on rising edge.
- `ap_rst`  in  1  reset, asynchronous, active-high.
- `i_address0`  in  ADDR_WIDTH  producer-side address.
- `i_ce0`  in  1  producer port enable.
- `i_we0`  in  1  producer write enable, qualified by `i_ce0`.
- `i_d0`  in  DATA_WIDTH  producer write data.
- `i_q0`  out  DATA_WIDTH  producer read-back data, 1-cycle latency.
- `i_write`  in  1  producer pulses this for 1 cycle to commit its bank (its ap_done).
- `i_full_n`  out  1  1 when a free bank is owned by the producer.
- `t_address0`  in  ADDR_WIDTH  consumer read address.
- `t_ce0`  in  1  consumer read enable.
- `t_q0`  out  DATA_WIDTH  consumer read data, 1-cycle latency.
- `t_read`  in  1  consumer pulses this for 1 cycle to release its bank.
- `t_empty_n`  out  1  1 when a committed bank is available to the consumer.

## Operation
- State: `iptr` (producer bank, 1 bit), `tptr` (consumer bank, 1 bit), `count` (committed banks, 0..2).
- Outputs: `i_full_n = (count != 2)`; `t_empty_n = (count != 0)`.
- Write: when `i_ce0 & i_we0 & i_full_n`, `bank[iptr][i_address0] <= i_d0`. Writes while `i_full_n=0` are dropped.
- Producer read: when `i_ce0 & ~i_we0`, `i_q0 <= bank[iptr][i_address0]`.
- Consumer read: when `t_ce0`, `t_q0 <= bank[tptr][t_address0]`. The read is performed even when `t_empty_n=0`; the data is then undefined.
- Commit: `i_write & i_full_n` toggles `iptr` and increments `count`. `i_write` while full is ignored.
- Release: `t_read & t_empty_n` toggles `tptr` and decrements `count`. `t_read` while empty is ignored.
- Commit and release accepted in the same cycle: both pointers toggle and `count` is unchanged.
- A write or read issued in the same cycle as `i_write`/`t_read` uses the pre-toggle pointer.
- Collision: same bank and same address written and read in one cycle (only possible at count=0) is read-first; `t_q0` returns the old word.
- Out-of-range addresses cannot occur because DEPTH = 2**ADDR_WIDTH.

## Timing
- Reset (async assert, sync release): `iptr=0`, `tptr=0`, `count=0`, `i_q0=0`, `t_q0=0`, hence `i_full_n=1`, `t_empty_n=0`. Bank contents are not reset.
- Read latency: exactly 1 cycle from `ce` to `q`. `q` holds its value while `ce=0`.
- `i_full_n`/`t_empty_n` update the cycle after the accepted `i_write`/`t_read` (registered from `count`).
- Minimum commit-to-visible latency: `i_write` at cycle N gives `t_empty_n=1` at N+1, and a consumer read issued at N+1 returns committed data at N+2.
- Reset mid-operation: pointers and count clear immediately and in-flight banks are discarded. Memory data survives but is not visible until recommitted.

## Structure
- Shared package `pingpong_pkg`: `DATA_WIDTH`/`ADDR_WIDTH` defaults, `count_t` (2-bit) typedef, and constants `CNT_EMPTY=0` and `CNT_FULL=2`.
- Sub-module `pingpong_bank`: one simple dual-port bank with a registered read port per side and read-first behaviour, instantiated twice. Port-to-bank steering and control logic live in the top.

## Test plan
- Reset: assert `ap_rst` asynchronously mid-cycle -> `i_full_n=1`, `t_empty_n=0`, `i_q0=t_q0=0` without waiting for a clock edge.
- Single pass: write 0,1,4,9,16 to addresses 0..4, pulse `i_write`, then read addresses 0..4 -> `t_q0` = 0,1,4,9,16, each 1 cycle after its `t_ce0`; `t_empty_n` rises the cycle after `i_write`.
- Ping-pong overlap: commit bank A (values 1..5), then while the consumer reads A, the producer writes bank B (values 10..50) -> consumer sees 1..5, then after `t_read` sees 10..50 with no corruption.
- Full: commit twice without `t_read` -> `i_full_n=0`. A further write of 99 and an `i_write` are ignored, `count` stays 2, and bank data is unchanged.
- Simultaneous: at count=1, pulse `i_write` and `t_read` in the same cycle -> `count` stays 1, both pointers toggle, flags unchanged.
- Empty misuse: `t_read` at count=0 -> ignored, `t_empty_n` stays 0. Same-address write/read at count=0 -> `t_q0` returns the prior word (read-first).
